// File: rtl/result_reader.sv
// Reads NUM_WORDS 32-bit words from an SRAM starting at BASE_ADDR and streams
// them to a host as bytes, LSB first, under valid/ready flow control.
module result_reader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cs_n,
  output logic        we_n,
  output logic [7:0]  address,
  input  logic        ry,
  input  logic [31:0] read_data,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   hold, hold_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [BYTE_W-1:0]   dout_nxt;
  logic                cs_n_nxt;
  logic                dout_valid_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // Byte lane select, lane 0 is the least significant byte.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] w,
                                                input logic [IDX_W-1:0]  i);
    logic [BYTE_W-1:0] b;
    b = w[7:0];
    case (i)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    hold_nxt  = hold;
    addr_nxt  = address;
    dout_nxt  = dout;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
          addr_nxt  = BASE_ADDR;
        end
      end
      REQ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ry) begin
          state_nxt = SEND;
          hold_nxt  = read_data;
          idx_nxt   = '0;
          dout_nxt  = read_data[7:0];
        end
      end
      SEND: begin
        if (dout_ready) begin
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_W'(3)) begin
            if (cnt == LAST_WORD) begin
              state_nxt = DONE;
            end else begin
              state_nxt = REQ;
              cnt_nxt   = cnt + CNT_W'(1);
              addr_nxt  = address + ADDR_W'(1);
            end
          end else begin
            dout_nxt = byte_of(hold, idx + IDX_W'(1));
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cs_n_nxt       = (state_nxt != REQ);
    dout_valid_nxt = (state_nxt == SEND);
    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = (state_nxt == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      hold       <= '0;
      address    <= BASE_ADDR;
      dout       <= '0;
      cs_n       <= 1'b1;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      hold       <= hold_nxt;
      address    <= addr_nxt;
      dout       <= dout_nxt;
      cs_n       <= cs_n_nxt;
      dout_valid <= dout_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // The block only ever reads.
  assign we_n = 1'b1;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: SRAM model with programmable ready delay, byte and
// address scoreboards, and one task per scenario.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Instance A: BASE_ADDR=0, NUM_WORDS=2
  logic        start = 1'b0;
  logic        cs_n, we_n;
  logic [7:0]  address;
  logic        ry = 1'b0;
  logic [31:0] read_data = 32'h0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        busy, done;

  // Instance B: BASE_ADDR=FE, NUM_WORDS=4, always-ready SRAM
  logic        start_b = 1'b0;
  logic        cs_n_b, we_n_b;
  logic [7:0]  address_b;
  logic        ry_b = 1'b1;
  logic [31:0] read_data_b;
  logic [7:0]  dout_b;
  logic        dout_valid_b;
  logic        dout_ready_b = 1'b1;
  logic        busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];
  int          ry_delay = 0;
  int          ry_cnt = 0;
  bit          pend = 1'b0;
  logic [7:0]  req_addr = 8'h00;

  logic [7:0]  byte_q[$];
  logic [7:0]  addr_q[$];
  logic [7:0]  byte_q_b[$];
  logic [7:0]  addr_q_b[$];
  int cs_pulses = 0, done_cnt = 0, bytes_seen = 0;
  int cs_pulses_b = 0, done_cnt_b = 0;

  result_reader #(.BASE_ADDR(8'h00), .NUM_WORDS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .cs_n(cs_n), .we_n(we_n),
    .address(address), .ry(ry), .read_data(read_data), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  result_reader #(.BASE_ADDR(8'hFE), .NUM_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cs_n(cs_n_b), .we_n(we_n_b),
    .address(address_b), .ry(ry_b), .read_data(read_data_b), .dout(dout_b),
    .dout_valid(dout_valid_b), .dout_ready(dout_ready_b), .busy(busy_b), .done(done_b)
  );

  assign read_data_b = {address_b, address_b, address_b, address_b};

  always #5 clk = ~clk;

  // SRAM model for A: ry rises ry_delay WAIT cycles after the request cycle.
  always @(posedge clk) begin
    #1;
    ry = 1'b0;
    if (!rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (ry_cnt == 0) begin
        ry        = 1'b1;
        read_data = mem[req_addr];
        pend      = 1'b0;
      end else begin
        ry_cnt = ry_cnt - 1;
      end
    end
    if (rst && !cs_n) begin
      pend     = 1'b1;
      ry_cnt   = ry_delay;
      req_addr = address;
    end
  end

  // Monitor A: compare requested addresses and transferred bytes.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      if (!cs_n) begin
        cs_pulses++;
        n_checks++;
        if (addr_q.size() == 0) begin
          n_errors++;
          $display("FAIL a_addr: unexpected request at address %h", address);
        end else begin
          e = addr_q.pop_front();
          if (address !== e) begin
            n_errors++;
            $display("FAIL a_addr: got %h expected %h", address, e);
          end
        end
      end
      if (dout_valid && dout_ready) begin
        bytes_seen++;
        n_checks++;
        if (byte_q.size() == 0) begin
          n_errors++;
          $display("FAIL a_byte: unexpected byte %h", dout);
        end else begin
          e = byte_q.pop_front();
          if (dout !== e) begin
            n_errors++;
            $display("FAIL a_byte: got %h expected %h", dout, e);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      if (!cs_n_b) begin
        cs_pulses_b++;
        n_checks++;
        if (addr_q_b.size() == 0) begin
          n_errors++;
          $display("FAIL b_addr: unexpected request at address %h", address_b);
        end else begin
          e = addr_q_b.pop_front();
          if (address_b !== e) begin
            n_errors++;
            $display("FAIL b_addr: got %h expected %h", address_b, e);
          end
        end
      end
      if (dout_valid_b && dout_ready_b) begin
        n_checks++;
        if (byte_q_b.size() == 0) begin
          n_errors++;
          $display("FAIL b_byte: unexpected byte %h", dout_b);
        end else begin
          e = byte_q_b.pop_front();
          if (dout_b !== e) begin
            n_errors++;
            $display("FAIL b_byte: got %h expected %h", dout_b, e);
          end
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic push_job_a();
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      addr_q.push_back(8'(i));
      w = mem[i];
      for (int b = 0; b < 4; b++) byte_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (cs_n !== 1'b1 || we_n !== 1'b1 || address !== 8'h00 || dout !== 8'h00 ||
        dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_a: cs_n=%b we_n=%b addr=%h dout=%h v=%b busy=%b done=%b, required 1 1 00 00 0 0 0",
               cs_n, we_n, address, dout, dout_valid, busy, done);
    end
    n_checks++;
    if (address_b !== 8'hFE || cs_n_b !== 1'b1 || busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_b: addr=%h cs_n=%b busy=%b, required FE 1 0", address_b, cs_n_b, busy_b);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic_stream();
    int first_valid = 0, done_at = 0, cs0 = cs_pulses, d0 = done_cnt;
    push_job_a();
    pulse_start();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dout_valid && first_valid == 0) first_valid = i;
      if (done) begin done_at = i; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (first_valid != 3) begin
      n_errors++;
      $display("FAIL latency: got %0d cycles required 3", first_valid);
    end
    n_checks++;
    if (done_at != 13) begin
      n_errors++;
      $display("FAIL job_cycles: done at cycle %0d required 13", done_at);
    end
    n_checks++;
    if (cs_pulses - cs0 != 2 || done_cnt - d0 != 1) begin
      n_errors++;
      $display("FAIL basic_counts: cs pulses %0d done pulses %0d, required 2 and 1",
               cs_pulses - cs0, done_cnt - d0);
    end
    n_checks++;
    if (byte_q.size() != 0) begin
      n_errors++;
      $display("FAIL basic_drain: %0d bytes left, required 0", byte_q.size());
    end
  endtask

  task automatic test_backpressure();
    int b0 = bytes_seen;
    bit seen = 1'b0;
    dout_ready = 1'b0;
    push_job_a();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dout_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || dout !== 8'h11) begin
      n_errors++;
      $display("FAIL bp_first: valid=%b dout=%h, required 1 11", seen, dout);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    @(posedge clk); #1 dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (dout !== 8'h22 || dout_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_hold: cycle %0d dout=%h valid=%b, required 22 1", i, dout, dout_valid);
      end
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen || bytes_seen - b0 != 8 || byte_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_total: done=%b bytes=%0d left=%0d, required 1 8 0",
               seen, bytes_seen - b0, byte_q.size());
    end
  endtask

  task automatic test_ry_wait();
    logic [7:0] a;
    bit seen = 1'b0;
    int b0 = bytes_seen;
    ry_delay = 10;
    push_job_a();
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (cs_n !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_req: cs_n=%b required 0", cs_n);
    end
    a = address;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (cs_n !== 1'b1 || address !== a || dout_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL wait_hold: cycle %0d cs_n=%b addr=%h valid=%b, required 1 %h 0",
                 i, cs_n, address, dout_valid, a);
      end
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    ry_delay = 0;
    n_checks++;
    if (!seen || bytes_seen - b0 != 8 || byte_q.size() != 0) begin
      n_errors++;
      $display("FAIL wait_total: done=%b bytes=%0d left=%0d, required 1 8 0",
               seen, bytes_seen - b0, byte_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    bit seen = 1'b0;
    int d0 = done_cnt;
    push_job_a();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout_valid && dout === 8'h55) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL rst_reach: word 1 byte 55 never presented");
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (cs_n !== 1'b1 || we_n !== 1'b1 || address !== 8'h00 || dout !== 8'h00 ||
        dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: cs_n=%b we_n=%b addr=%h dout=%h v=%b busy=%b done=%b, required 1 1 00 00 0 0 0",
               cs_n, we_n, address, dout, dout_valid, busy, done);
    end
    byte_q.delete();
    addr_q.delete();
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_abort: done pulses %0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
    push_job_a();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen || byte_q.size() != 0 || addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL rst_restart: done=%b bytes left=%0d addrs left=%0d, required 1 0 0",
               seen, byte_q.size(), addr_q.size());
    end
  endtask

  task automatic test_start_ignored();
    bit seen = 1'b0;
    int b0 = bytes_seen, d0 = done_cnt, c0 = cs_pulses;
    push_job_a();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || cs_n !== 1'b1) begin
        n_errors++;
        $display("FAIL start_restart: cycle %0d busy=%b cs_n=%b, required 0 1", i, busy, cs_n);
      end
    end
    n_checks++;
    if (!seen || bytes_seen - b0 != 8 || done_cnt - d0 != 1 || cs_pulses - c0 != 2) begin
      n_errors++;
      $display("FAIL start_total: done=%b bytes=%0d dones=%0d cs=%0d, required 1 8 1 2",
               seen, bytes_seen - b0, done_cnt - d0, cs_pulses - c0);
    end
  endtask

  task automatic test_addr_wrap();
    bit seen = 1'b0;
    int c0 = cs_pulses_b;
    logic [7:0] a;
    a = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      addr_q_b.push_back(a);
      for (int b = 0; b < 4; b++) byte_q_b.push_back(a);
      a = a + 8'd1;
    end
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_b) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen || cs_pulses_b - c0 != 4 || addr_q_b.size() != 0 || byte_q_b.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_total: done=%b cs=%0d addrs left=%0d bytes left=%0d, required 1 4 0 0",
               seen, cs_pulses_b - c0, addr_q_b.size(), byte_q_b.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_ry_wait();
    test_reset_mid_job();
    test_start_ignored();
    test_addr_wrap();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first SRAM word address read.
REQ-002 SHALL have parameter NUM_WORDS, default 16: words read per job, legal range 1..256.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begins a job when sampled high in IDLE.
REQ-006 SHALL have port cs_n, output, 1: SRAM chip select, active-low.
REQ-007 SHALL have port we_n, output, 1: SRAM write enable, active-low; always driven 1.
REQ-008 SHALL have port address, output, 8: SRAM word address.
REQ-009 SHALL have port ry, input, 1: SRAM ready; read_data is valid in any cycle where ry=1 follows a request.
REQ-010 SHALL have port read_data, input, 32: SRAM read word.
REQ-011 SHALL have port dout, output, 8: byte stream to host.
REQ-012 SHALL have port dout_valid, output, 1: dout holds a valid byte.
REQ-013 SHALL have port dout_ready, input, 1: host accepts the byte; a transfer occurs when dout_valid=1 and dout_ready=1 on a clock edge.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at job end.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, SEND, DONE.
REQ-017 IDLE->REQ on start=1, SHALL load the word counter with 0 and address with BASE_ADDR.
REQ-018 In REQ, SHALL drive cs_n=0 for exactly one cycle with the current address, then go to WAIT.
REQ-019 In WAIT, cs_n SHALL be 1 and address SHALL hold; the first cycle with ry=1 SHALL capture read_data into a 32-bit hold register and go to SEND. There is no timeout; WAIT holds indefinitely while ry=0.
REQ-020 In SEND, SHALL assert dout_valid=1 and present bytes LSB-first: hold[7:0], [15:8], [23:16], [31:24], using a 2-bit byte index.
REQ-021 dout and dout_valid SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-022 Each transfer SHALL advance the byte index. On the transfer of byte 3, SHALL go to DONE if word counter = NUM_WORDS-1. Otherwise SHALL increment the counter and address and go to REQ.
REQ-023 address SHALL increment modulo 256; BASE_ADDR+NUM_WORDS>256 wraps to 8'h00.
REQ-024 DONE SHALL assert done=1 for one cycle and return to IDLE; dout_valid=0 in DONE.
REQ-025 start SHALL be ignored outside IDLE, and a start asserted in the DONE cycle SHALL be ignored.
REQ-026 Outside SEND, dout_valid SHALL be 0; dout SHALL hold its last value.
REQ-027 Minimum latency from start to first dout_valid SHALL be 3 cycles (REQ, WAIT with ry=1, SEND), measured with ry=1 in the first WAIT cycle.
REQ-028 Per-word throughput with dout_ready=1 and immediate ry SHALL be 6 cycles: REQ, WAIT, 4x SEND.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, cs_n=1, we_n=1, address=BASE_ADDR, dout=0, dout_valid=0, busy=0, done=0, counter=0, byte index=0, hold=0.
REQ-030 Reset asserted mid-job SHALL abort the job with no done pulse. After release, the block SHALL wait for a new start.

Verification
REQ-031 BASE_ADDR=0, NUM_WORDS=2, SRAM[0]=32'h44332211, SRAM[1]=32'h88776655, ry one cycle after cs_n, dout_ready=1 -> dout sequence 11,22,33,44,55,66,77,88, then a single done pulse, with 2 cs_n pulses at addresses 0 and 1.
REQ-032 Hold dout_ready=0 for 5 cycles while byte 22 is presented -> dout=8'h22 and dout_valid=1 stable for all 5 cycles, with no byte lost or duplicated.
REQ-033 ry held 0 for 10 cycles after the request -> cs_n=1, address stable, dout_valid=0 throughout; the stream resumes correctly once ry=1.
REQ-034 BASE_ADDR=8'hFE, NUM_WORDS=4 -> addresses FE, FF, 00, 01 requested in order.
REQ-035 rst pulsed low during SEND of word 1 -> all outputs at reset values immediately with no done pulse; a new start afterwards reads from BASE_ADDR again.
REQ-036 start pulsed while busy and in the DONE cycle -> no restart, and exactly NUM_WORDS*4 bytes are emitted for the job.
